// File: rtl/gps_pkg.sv
// Shared constants and helpers for the GPS receiver service-request path.
package gps_pkg;

   localparam int CHANS_DEF = 12;
   localparam int REP_W_DEF = 16;
   localparam int OVR_W_DEF = 4;

   // Width of the snapshot word: pending bit, overrun count and replica per channel.
   function automatic int snap_w(input int chans, input int rep_w, input int ovr_w);
      return chans * (1 + ovr_w + rep_w);
   endfunction

   // The host request sits just above the channel flags.
   function automatic int host_bit(input int chans);
      return chans;
   endfunction

endpackage

// File: rtl/srq_ovr_counter.sv
// One saturating overrun counter.
// Priority: mask clear > snapshot clear (or set-to-1 if incrementing) > increment.
module srq_ovr_counter
   import gps_pkg::*;
#(
   parameter int OVR_W = OVR_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mask_clr_i,
   input  logic             snap_clr_i,
   input  logic             inc_i,
   output logic [OVR_W-1:0] count_o
);

   localparam logic [OVR_W-1:0] SAT = '1;

   logic [OVR_W-1:0] count_q, count_d;

   // Next count: clears first, then a saturating increment.
   always_comb begin
      count_d = count_q;
      if (mask_clr_i) begin
         count_d = '0;
      end else if (snap_clr_i) begin
         count_d = inc_i ? OVR_W'(1) : '0;
      end else if (inc_i && (count_q != SAT)) begin
         count_d = count_q + OVR_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/srq_snapshot_unit.sv
// Service-request collector and replica snapshot unit.
// Pulses are held in sticky noted flags, masked into an MSB-first SRQ shifter,
// and a coherent {pending, overrun counts, replicas} word is captured into a
// second shifter for serial readout. Load and shift strobes of the two
// shifters are independent; load wins over shift within one shifter.
module srq_snapshot_unit
   import gps_pkg::*;
#(
   parameter int CHANS = CHANS_DEF,
   parameter int REP_W = REP_W_DEF,
   parameter int OVR_W = OVR_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [CHANS-1:0]       chan_srq,
   input  logic                   host_srq,
   input  logic                   mask_wr,
   input  logic [CHANS-1:0]       mask_din,
   input  logic [CHANS*REP_W-1:0] replicas,
   input  logic                   load_srq,
   input  logic                   shift_srq,
   input  logic                   load_snap,
   input  logic                   shift_snap,
   output logic                   ser_srq,
   output logic                   ser_snap,
   output logic [CHANS-1:0]       chan_mask,
   output logic                   irq
);

   localparam int HOST_BIT = host_bit(CHANS);
   localparam int FLAG_W   = CHANS + 1;
   localparam int SNAP_W   = snap_w(CHANS, REP_W, OVR_W);

   logic [FLAG_W-1:0]      flags, eff_mask;
   logic [FLAG_W-1:0]      noted_q, noted_d;
   logic [FLAG_W-1:0]      srq_shift_q, srq_shift_d;
   logic [CHANS-1:0]       chan_mask_q, chan_mask_d;
   logic [CHANS-1:0]       pending, ovr_inc, ovr_mask_clr;
   logic [CHANS*OVR_W-1:0] ovr_flat;
   logic [SNAP_W-1:0]      snapshot_q, snapshot_d;
   logic                   irq_q, irq_d;

   assign flags    = {host_srq, chan_srq};
   assign eff_mask = {1'b1, chan_mask_q};
   assign pending  = chan_srq | noted_q[CHANS-1:0];

   // A repeat epoch on a still-noted, unmasked channel is an overrun; the
   // cycle that opens a new noted window never counts.
   assign ovr_inc      = chan_srq & noted_q[CHANS-1:0] & chan_mask_q & {CHANS{~load_srq}};
   assign ovr_mask_clr = {CHANS{mask_wr}} & ~mask_din;

   // Per-channel overrun counters; channel i lands at ovr_flat[i*OVR_W +: OVR_W].
   for (genvar i = 0; i < CHANS; i++) begin : g_ovr
      srq_ovr_counter #(
         .OVR_W(OVR_W)
      ) u_ovr (
         .clk       (clk),
         .rst_n     (rst_n),
         .mask_clr_i(ovr_mask_clr[i]),
         .snap_clr_i(load_snap),
         .inc_i     (ovr_inc[i]),
         .count_o   (ovr_flat[i*OVR_W +: OVR_W])
      );
   end

   // Next-state for noted flags, both shifters, mask and interrupt.
   always_comb begin
      noted_d     = load_srq ? flags : (noted_q | flags);
      srq_shift_d = srq_shift_q;
      if (load_srq) begin
         srq_shift_d = noted_q & eff_mask;
      end else if (shift_srq) begin
         srq_shift_d = srq_shift_q << 1;
      end
      snapshot_d = snapshot_q;
      if (load_snap) begin
         snapshot_d = {pending, ovr_flat, replicas};
      end else if (shift_snap) begin
         snapshot_d = snapshot_q << 1;
      end
      chan_mask_d = mask_wr ? mask_din : chan_mask_q;
      irq_d       = |(noted_d & eff_mask);
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         noted_q     <= '0;
         srq_shift_q <= '0;
         snapshot_q  <= '0;
         chan_mask_q <= '0;
         irq_q       <= 1'b0;
      end else begin
         noted_q     <= noted_d;
         srq_shift_q <= srq_shift_d;
         snapshot_q  <= snapshot_d;
         chan_mask_q <= chan_mask_d;
         irq_q       <= irq_d;
      end
   end

   assign ser_srq   = srq_shift_q[HOST_BIT];
   assign ser_snap  = snapshot_q[SNAP_W-1];
   assign chan_mask = chan_mask_q;
   assign irq       = irq_q;

endmodule
